// File: rtl/vs_spi_responder_if.sv
// Serial bus between the host master and the codec-style SPI responder.
interface vs_spi_responder_if;
    logic i_XRST;
    logic i_XCS;
    logic i_XDCS;
    logic i_SCK;
    logic i_SI;
    logic o_DREQ;
    logic o_SO;

    modport master (
        output i_XRST, i_XCS, i_XDCS, i_SCK, i_SI,
        input  o_DREQ, o_SO
    );

    modport slave (
        input  i_XRST, i_XCS, i_XDCS, i_SCK, i_SI,
        output o_DREQ, o_SO
    );
endinterface

// File: rtl/vs_spi_responder.sv
// Codec-style SPI responder: SCI register file (32-bit frames), SDI byte FIFO
// drained at a fixed rate, boot/soft-reset hold-off and DREQ flow control.
module vs_spi_responder #(
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned DRAIN_DIV   = 64,
    parameter int unsigned BOOT_CYCLES = 1000,
    parameter int unsigned DREQ_FREE   = 2
) (
    input  logic                          clk_temp,
    input  logic                          rst_n,
    vs_spi_responder_if.slave             spi,
    output logic [15:0]                   o_mode,
    output logic [15:0]                   o_vol,
    output logic [7:0]                    o_byte,
    output logic                          o_byte_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_ovf,
    output logic                          o_err
);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned DCW = $clog2(DRAIN_DIV);
    localparam int unsigned BCW = $clog2(BOOT_CYCLES + 1);

    typedef enum logic [2:0] {HOLD, BOOT, IDLE, SCI_RX, SDI_RX, SRESET} state_t;

    state_t           state;
    logic [4:0]       sync1, sync2;
    logic             sck_d;
    logic             xrst_s, xcs_s, xdcs_s, sck_s, si_s;
    logic             sck_rise, sck_fall;
    logic [BCW-1:0]   boot_cnt;
    logic [5:0]       bit_cnt;
    logic [30:0]      sh;
    logic [31:0]      sh_next;
    logic [15:0]      rd_word;
    logic [DCW-1:0]   drain_cnt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [15:0]      regs [16];
    logic             dreq_q, so_q;
    logic             active, full, empty;
    logic             sdi_done, push_ok, pop_ok;
    logic             sci_last, sci_wr, flush;

    assign {xrst_s, xcs_s, xdcs_s, sck_s, si_s} = sync2;
    assign sck_rise   = sck_s & ~sck_d;
    assign sck_fall   = ~sck_s & sck_d;
    assign o_mode     = regs[0];
    assign o_vol      = regs[11];
    assign spi.o_DREQ = dreq_q;
    assign spi.o_SO   = so_q;

    // Two-flop synchronizers for all master-driven pins, plus SCK edge history.
    always_ff @(posedge clk_temp or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 5'b01100;
            sync2 <= 5'b01100;
            sck_d <= 1'b0;
        end else begin
            sync1 <= {spi.i_XRST, spi.i_XCS, spi.i_XDCS, spi.i_SCK, spi.i_SI};
            sync2 <= sync1;
            sck_d <= sck_s;
        end
    end

    // Frame decode strobes and FIFO push/pop/flush decisions.
    always_comb begin
        active   = (state == IDLE) || (state == SCI_RX) || (state == SDI_RX);
        full     = (o_level == LW'(FIFO_DEPTH));
        empty    = (o_level == '0);
        sh_next  = {sh, si_s};
        sdi_done = xrst_s && (state == SDI_RX) && !xdcs_s && sck_rise && (bit_cnt[2:0] == 3'd7);
        push_ok  = sdi_done && !full;
        pop_ok   = xrst_s && active && (drain_cnt == DCW'(DRAIN_DIV - 1)) && !empty;
        sci_last = xrst_s && (state == SCI_RX) && !xcs_s && sck_rise && (bit_cnt == 6'd31);
        sci_wr   = sci_last && (sh_next[31:24] == 8'h02) && (sh_next[23:20] == 4'h0);
        flush    = sci_wr && (sh_next[19:16] == 4'h0) && sh_next[2];
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_temp) begin
        if (push_ok)
            mem[wr_ptr] <= sh_next[7:0];
    end

    // Main state machine: boot hold-off, SCI/SDI reception, FIFO control, flags.
    always_ff @(posedge clk_temp or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;  boot_cnt <= '0;  bit_cnt <= '0;  sh <= '0;  rd_word <= '0;
            drain_cnt <= '0;  wr_ptr <= '0;  rd_ptr <= '0;  o_level <= '0;
            o_byte <= '0;  o_byte_valid <= 1'b0;  o_ovf <= 1'b0;  o_err <= 1'b0;
            dreq_q <= 1'b0;  so_q <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
            regs[0] <= 16'h0800;
        end else if (!xrst_s) begin
            state <= HOLD;  boot_cnt <= '0;  bit_cnt <= '0;  sh <= '0;  rd_word <= '0;
            drain_cnt <= '0;  wr_ptr <= '0;  rd_ptr <= '0;  o_level <= '0;
            o_byte <= '0;  o_byte_valid <= 1'b0;  o_ovf <= 1'b0;  o_err <= 1'b0;
            dreq_q <= 1'b0;  so_q <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
            regs[0] <= 16'h0800;
        end else begin
            o_byte_valid <= 1'b0;
            dreq_q       <= active && (o_level <= LW'(FIFO_DEPTH - DREQ_FREE));

            if (active)
                drain_cnt <= (drain_cnt == DCW'(DRAIN_DIV - 1)) ? '0 : drain_cnt + 1'b1;
            else
                drain_cnt <= '0;

            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                o_level <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok) begin
                    rd_ptr       <= rd_ptr + 1'b1;
                    o_byte       <= mem[rd_ptr];
                    o_byte_valid <= 1'b1;
                end
                if (push_ok && !pop_ok)
                    o_level <= o_level + 1'b1;
                else if (!push_ok && pop_ok)
                    o_level <= o_level - 1'b1;
            end

            if (sdi_done && full)
                o_ovf <= 1'b1;

            case (state)
                HOLD: begin
                    state    <= BOOT;
                    boot_cnt <= '0;
                end
                BOOT, SRESET: begin
                    if (boot_cnt == BCW'(BOOT_CYCLES - 1))
                        state <= IDLE;
                    else
                        boot_cnt <= boot_cnt + 1'b1;
                end
                IDLE: begin
                    bit_cnt <= '0;
                    sh      <= '0;
                    rd_word <= '0;
                    so_q    <= 1'b0;
                    if (!xcs_s && !xdcs_s)
                        o_err <= 1'b1;
                    else if (!xcs_s)
                        state <= SCI_RX;
                    else if (!xdcs_s)
                        state <= SDI_RX;
                end
                SCI_RX: begin
                    if (xcs_s) begin
                        if (bit_cnt != 6'd32)
                            o_err <= 1'b1;
                        so_q  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (sck_rise && (bit_cnt != 6'd32)) begin
                            sh      <= sh_next[30:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if ((bit_cnt == 6'd7) && (sh_next[7:0] != 8'h02) && (sh_next[7:0] != 8'h03))
                                o_err <= 1'b1;
                            // Read data is latched once the address byte completes.
                            if (bit_cnt == 6'd15)
                                rd_word <= (sh_next[15:8] == 8'h03) ? regs[sh_next[3:0]] : '0;
                            if (sci_last && (sh_next[31:24] == 8'h02) && (sh_next[23:20] != 4'h0))
                                o_err <= 1'b1;
                            if (sci_wr) begin
                                if (sh_next[19:16] == 4'h0)
                                    regs[0] <= sh_next[15:0] & ~16'h0004;
                                else
                                    regs[sh_next[19:16]] <= sh_next[15:0];
                                if (flush) begin
                                    state    <= SRESET;
                                    boot_cnt <= '0;
                                    so_q     <= 1'b0;
                                end
                            end
                        end
                        // ~bit_cnt[3:0] maps completed bits 16..31 onto data bits 15..0.
                        if (sck_fall)
                            so_q <= (bit_cnt >= 6'd16 && bit_cnt < 6'd32) ? rd_word[~bit_cnt[3:0]] : 1'b0;
                    end
                end
                SDI_RX: begin
                    if (xdcs_s)
                        state <= IDLE;
                    else if (sck_rise) begin
                        sh      <= sh_next[30:0];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_vs_spi_responder.sv
// Directed bench for vs_spi_responder with a byte-strobe scoreboard.
module tb_vs_spi_responder;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DIV   = 1024;
    localparam int unsigned BOOT  = 40;
    localparam int unsigned FREE  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mode, vol;
    logic [7:0]  obyte;
    logic        obyte_valid;
    logic [3:0]  level;
    logic        ovf, err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int low_run  = 0;
    int last_low = 0;
    logic [7:0] exp_q[$];
    int         strobe_cyc[$];

    vs_spi_responder_if bus();

    vs_spi_responder #(
        .FIFO_DEPTH (DEPTH),
        .DRAIN_DIV  (DIV),
        .BOOT_CYCLES(BOOT),
        .DREQ_FREE  (FREE)
    ) dut (
        .clk_temp    (clk),
        .rst_n       (rst_n),
        .spi         (bus),
        .o_mode      (mode),
        .o_vol       (vol),
        .o_byte      (obyte),
        .o_byte_valid(obyte_valid),
        .o_level     (level),
        .o_ovf       (ovf),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard monitor: every byte strobe is matched against the expected queue.
    always @(negedge clk) begin
        if (obyte_valid === 1'b1) begin
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL byte_unexpected actual=%0h required=none", obyte);
            end else begin
                chk("o_byte", {24'h0, obyte}, {24'h0, exp_q.pop_front()});
            end
        end
        if (bus.o_DREQ !== 1'b1) low_run++;
        else begin
            if (low_run != 0) last_low = low_run;
            low_run = 0;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_dreq(input string name, input int maxc, output int n);
        n = 0;
        while (bus.o_DREQ !== 1'b1 && n < maxc) begin
            wait_cyc(1);
            n++;
        end
        if (bus.o_DREQ !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual_cycles=%0d required_dreq=1", name, n);
        end
    endtask

    task automatic sci(input logic [31:0] w, input int nbits, input bit release_cs,
                       output logic [15:0] so_w);
        logic [31:0] s;
        s    = w;
        so_w = '0;
        bus.i_XCS = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < nbits; i++) begin
            bus.i_SI = s[31];
            s = {s[30:0], 1'b0};
            wait_cyc(4);
            if (i >= 16) so_w = {so_w[14:0], bus.o_SO};
            bus.i_SCK = 1'b1;
            wait_cyc(4);
            bus.i_SCK = 1'b0;
        end
        bus.i_SI = 1'b0;
        wait_cyc(6);
        if (release_cs) begin
            bus.i_XCS = 1'b1;
            wait_cyc(6);
        end
    endtask

    task automatic sdi(input logic [7:0] b);
        logic [7:0] s;
        s = b;
        bus.i_XDCS = 1'b0;
        wait_cyc(4);
        repeat (8) begin
            bus.i_SI = s[7];
            s = {s[6:0], 1'b0};
            wait_cyc(4);
            bus.i_SCK = 1'b1;
            wait_cyc(4);
            bus.i_SCK = 1'b0;
        end
        bus.i_SI = 1'b0;
        wait_cyc(4);
        bus.i_XDCS = 1'b1;
        wait_cyc(6);
    endtask

    task automatic xrst_pulse();
        int n;
        bus.i_XRST = 1'b0;
        wait_cyc(6);
        bus.i_XRST = 1'b1;
        wait_dreq("xrst_reboot", BOOT + 50, n);
    endtask

    initial begin
        logic [15:0] so_w;
        int n;
        rst_n = 1'b0;
        bus.i_XRST = 1'b0; bus.i_XCS = 1'b1; bus.i_XDCS = 1'b1;
        bus.i_SCK = 1'b0;  bus.i_SI = 1'b0;
        wait_cyc(5);

        // Reset values
        chk("rst_dreq",  bus.o_DREQ, 0);
        chk("rst_so",    bus.o_SO, 0);
        chk("rst_mode",  mode, 16'h0800);
        chk("rst_vol",   vol, 0);
        chk("rst_byte",  obyte, 0);
        chk("rst_valid", obyte_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf",   ovf, 0);
        chk("rst_err",   err, 0);

        // Boot hold-off
        rst_n = 1'b1;
        wait_cyc(3);
        chk("hold_dreq", bus.o_DREQ, 0);
        bus.i_XRST = 1'b1;
        wait_dreq("boot", BOOT + 50, n);
        chk_rng("boot_len", n, BOOT, BOOT + 6);
        chk("boot_mode", mode, 16'h0800);

        // SCI write then read back of VOL
        sci(32'h020B_2020, 32, 1'b1, so_w);
        chk("vol_write", vol, 16'h2020);
        sci(32'h030B_0000, 32, 1'b1, so_w);
        chk("vol_read_so", so_w, 16'h2020);
        chk("so_idle", bus.o_SO, 0);
        chk("err_clean", err, 0);

        // Two SDI bytes drained DRAIN_DIV apart
        strobe_cyc.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        sdi(8'hA5);
        sdi(8'h3C);
        chk("level_two", level, 2);
        n = 0;
        while (strobe_cyc.size() < 2 && n < 3 * DIV) begin
            wait_cyc(1);
            n++;
        end
        if (strobe_cyc.size() < 2) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual_strobes=%0d required=2", strobe_cyc.size());
        end else begin
            chk("drain_spacing", strobe_cyc[1] - strobe_cyc[0], DIV);
        end

        // Soft reset: bytes in FIFO are flushed, MODE stored with SM_RESET cleared
        sdi(8'h11);
        sdi(8'h22);
        chk("level_pre_flush", level, 2);
        sci(32'h0200_0804, 32, 1'b1, so_w);
        chk("sreset_mode", mode, 16'h0800);
        chk("sreset_level", level, 0);
        chk("sreset_vol_kept", vol, 16'h2020);
        chk("sreset_dreq", bus.o_DREQ, 0);
        wait_dreq("sreset", BOOT + 50, n);
        wait_cyc(1);
        chk_rng("sreset_low_len", last_low, BOOT, BOOT + 1);

        // Overflow: FIFO_DEPTH+1 bytes inside one drain period
        for (int k = 1; k <= DEPTH + 1; k++) begin
            sdi(8'(8'h40 + k));
            if (k <= DEPTH) exp_q.push_back(8'(8'h40 + k));
            chk("ovf_level", level, (k <= DEPTH) ? k : DEPTH);
            chk("ovf_dreq", bus.o_DREQ, (k <= DEPTH - FREE) ? 1 : 0);
            chk("ovf_flag", ovf, (k > DEPTH) ? 1 : 0);
        end
        n = 0;
        while (exp_q.size() != 0 && n < (DEPTH + 2) * DIV) begin
            wait_cyc(1);
            n++;
        end
        chk("drain_all", exp_q.size(), 0);
        wait_cyc(2);
        chk("drained_level", level, 0);
        chk("drained_dreq", bus.o_DREQ, 1);

        // Truncated frame
        chk("err_before_trunc", err, 0);
        sci(32'h020B_FFFF, 12, 1'b1, so_w);
        chk("trunc_err", err, 1);
        chk("trunc_vol", vol, 16'h2020);

        // Hardware reset mid-frame
        sci(32'h020B_1111, 20, 1'b0, so_w);
        bus.i_XRST = 1'b0;
        wait_cyc(5);
        bus.i_XCS = 1'b1;
        wait_cyc(2);
        chk("xrst_mode", mode, 16'h0800);
        chk("xrst_vol", vol, 0);
        chk("xrst_err", err, 0);
        chk("xrst_ovf", ovf, 0);
        chk("xrst_dreq", bus.o_DREQ, 0);
        bus.i_XRST = 1'b1;
        wait_dreq("xrst_boot", BOOT + 50, n);

        // Both selects low
        sci(32'h020B_1234, 32, 1'b1, so_w);
        chk("vol_1234", vol, 16'h1234);
        sci(32'h0300_0000, 32, 1'b1, so_w);
        chk("mode_read_so", so_w, 16'h0800);
        bus.i_XCS = 1'b0; bus.i_XDCS = 1'b0;
        wait_cyc(8);
        bus.i_XCS = 1'b1; bus.i_XDCS = 1'b1;
        wait_cyc(8);
        chk("both_low_err", err, 1);
        chk("both_low_vol", vol, 16'h1234);
        chk("both_low_mode", mode, 16'h0800);

        // Bad opcode
        xrst_pulse();
        sci(32'h070B_5555, 32, 1'b1, so_w);
        chk("badop_err", err, 1);
        chk("badop_vol", vol, 0);

        // Write to an address with upper nibble set
        xrst_pulse();
        sci(32'h021B_5555, 32, 1'b1, so_w);
        chk("badaddr_err", err, 1);
        chk("badaddr_vol", vol, 0);

        wait_cyc(20);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vs_spi_responder.md
VS_SPI_RESPONDER -- requirements
Module: vs_spi_responder

Interface
REQ-001 Parameter FIFO_DEPTH, 32, SDI byte FIFO depth in bytes (power of 2).
REQ-002 Parameter DRAIN_DIV, 64, clk_temp cycles between FIFO pops.
REQ-003 Parameter BOOT_CYCLES, 1000, DREQ-low hold after hardware or soft reset.
REQ-004 Parameter DREQ_FREE, 2, minimum free FIFO bytes for DREQ high.
REQ-005 Reset rst_n is asynchronous and active-low; the clock is clk_temp.
REQ-006 clk_temp  in  1  system clock; all logic on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 i_XRST  in  1  codec hardware reset from master, active-low.
REQ-009 i_XCS, i_XDCS, i_SCK, i_SI  in  1 each  SCI select, SDI select, serial clock, serial data.
REQ-010 o_DREQ  out  1  ready for more SCI/SDI traffic.
REQ-011 o_SO  out  1  SCI read data.
REQ-012 o_mode, o_vol  out  16 each  register 0x0 (MODE) and register 0xB (VOL).
REQ-013 o_byte, o_byte_valid  out  8, 1  drained SDI byte and one-cycle strobe.
REQ-014 o_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 o_ovf, o_err  out  1 each  sticky FIFO overflow, sticky protocol error.

Function
REQ-016 i_XCS, i_XDCS, i_SCK, i_SI SHALL pass through 2-flop synchronizers; SCK rising edge is detected on synchronized values; SCK high and low phases each >= 2 clk_temp cycles.
REQ-017 Bits SHALL be sampled MSB-first on SCK rising edge; o_SO SHALL change on SCK falling edge.
REQ-018 States: HOLD, BOOT, IDLE, SCI_RX, SDI_RX, SRESET.
REQ-019 HOLD while i_XRST=0: register file, FIFO, counters cleared, o_DREQ=0; i_XRST=1 -> BOOT.
REQ-020 BOOT/SRESET: count BOOT_CYCLES with o_DREQ=0 and serial input ignored, then IDLE.
REQ-021 IDLE: XCS=0 -> SCI_RX; XDCS=0 -> SDI_RX; both low -> set o_err, stay IDLE.
REQ-022 SCI frame is 32 bits: opcode[7:0], addr[7:0], data[15:0]; opcode 0x02 write, 0x03 read, other -> o_err, remaining bits ignored.
REQ-023 Write: after bit 32, reg[addr[3:0]] <= data; addr[7:4]!=0 -> o_err, no write.
REQ-024 Read: o_SO drives reg[addr[3:0]] bits 15..0 during bits 17..32; o_SO=0 otherwise.
REQ-025 XCS rising before 32 bits: frame discarded, o_err set, -> IDLE; after 32 bits -> IDLE on XCS high; extra bits ignored.
REQ-026 MODE write with bit 2 (SM_RESET) set: stored value has bit 2 cleared, FIFO flushed, -> SRESET; other registers kept.
REQ-027 SDI_RX: every 8 bits one byte pushed to FIFO; XDCS rising discards a partial byte without error, -> IDLE.
REQ-028 Push when full: byte dropped, o_ovf set; FIFO state unchanged.
REQ-029 Drain counter counts 0..DRAIN_DIV-1 in IDLE/SCI_RX/SDI_RX; at wrap, if non-empty, pop: o_byte=head, o_byte_valid=1 one cycle.
REQ-030 Simultaneous push and pop in one cycle SHALL both occur; o_level unchanged.
REQ-031 o_DREQ=1 only in IDLE/SCI_RX/SDI_RX with FIFO_DEPTH-o_level >= DREQ_FREE, registered (1-cycle latency from level change).
REQ-032 o_ovf, o_err clear only on rst_n or i_XRST=0.

Reset
REQ-033 rst_n=0 SHALL force HOLD regardless of i_XRST; outputs: o_DREQ=0, o_SO=0, o_mode=0x0800, o_vol=0x0000, o_byte=0, o_byte_valid=0, o_level=0, o_ovf=0, o_err=0; all other registers 0.
REQ-034 i_XRST=0 mid-frame SHALL abort the frame, reload the REQ-033 values, without setting o_err.

Verification
REQ-035 rst_n release, i_XRST rises -> o_DREQ=0 for BOOT_CYCLES, then 1; o_mode=0x0800.
REQ-036 SCI 0x02_0B_2020 -> o_vol=0x2020; SCI 0x03_0B_0000 -> o_SO shifts 0x2020 MSB-first.
REQ-037 SCI 0x02_00_0804 -> o_mode=0x0800, FIFO flushed, o_DREQ low BOOT_CYCLES.
REQ-038 SDI bytes 0xA5,0x3C -> o_byte_valid strobes with 0xA5 then 0x3C, DRAIN_DIV apart.
REQ-039 FIFO_DEPTH+1 bytes with no drain -> o_DREQ falls at FIFO_DEPTH-DREQ_FREE+1 bytes, last byte dropped, o_ovf=1.
REQ-040 XCS high after 12 bits; XCS and XDCS both low -> o_err=1, registers unchanged.
